// File: rtl/fuzzy_step_sched_2_if.sv
// Handshake and inference-table signals of the phase-2 fuzzy step sequencer.
// The slave modport is the sequencer. The master modport is the sample source, the sink and the table.
interface fuzzy_step_sched_2_if #(
    parameter int W     = 16,
    parameter int OUT_W = 16
) ();
    logic                    in_valid;
    logic                    in_ready;
    logic signed [W-1:0]     in_err;
    logic [4:0]              fuzzy_EC;
    logic [4:0]              fuzzy_df;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_u;
    logic                    df_err;
    logic                    busy;

    modport slave (
        input  in_valid, in_err, fuzzy_df, out_ready,
        output in_ready, fuzzy_EC, out_valid, out_u, df_err, busy
    );

    modport master (
        output in_valid, in_err, fuzzy_df, out_ready,
        input  in_ready, fuzzy_EC, out_valid, out_u, df_err, busy
    );
endinterface

// File: rtl/fuzzy_step_sched_2.sv
// Phase-2 fuzzy step sequencer. It forms the error change, quantises it to a 17-level index and
// integrates the table result into a saturating control value. One sample takes six cycles.
module fuzzy_step_sched_2 #(
    parameter int W      = 16,
    parameter int QSHIFT = 4,
    parameter int GAIN   = 1,
    parameter int OUT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    fuzzy_step_sched_2_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_DIFF,
        S_QUANT,
        S_INFER,
        S_ACC,
        S_OUT
    } state_t;

    // Wide enough for out_u + 8*GAIN with GAIN up to 2^(OUT_W-1).
    localparam int SUM_W = OUT_W + 8;

    localparam logic signed [W:0]       Q_MAX    = (W+1)'(8);
    localparam logic signed [W:0]       Q_MIN    = (W+1)'(-8);
    localparam logic signed [OUT_W-1:0] OUT_MAX  = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN  = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic signed [SUM_W-1:0] SUM_MAX  = {{(SUM_W-OUT_W){1'b0}}, OUT_MAX};
    localparam logic signed [SUM_W-1:0] SUM_MIN  = {{(SUM_W-OUT_W){1'b1}}, OUT_MIN};
    localparam logic signed [SUM_W-1:0] GAIN_EXT = SUM_W'(GAIN);

    state_t                  state_q;
    logic signed [W-1:0]     e_cur_q;
    logic signed [W-1:0]     e_prev_q;
    logic                    first_q;
    logic signed [W:0]       ec_q;
    logic [4:0]              level_q;
    logic [4:0]              df_q;
    logic signed [OUT_W-1:0] out_u_q;
    logic                    out_valid_q;
    logic                    in_ready_q;
    logic                    busy_q;
    logic                    df_err_q;

    logic signed [W:0]       ec_d;
    logic signed [W:0]       q_shift;
    logic [4:0]              level_d;
    logic signed [5:0]       delta;
    logic signed [SUM_W-1:0] sum_full;
    logic signed [OUT_W-1:0] sum_d;

    always_comb begin
        ec_d    = $signed({e_cur_q[W-1], e_cur_q}) - $signed({e_prev_q[W-1], e_prev_q});
        q_shift = ec_q >>> QSHIFT;
        if (q_shift > Q_MAX) begin
            level_d = 5'd16;
        end else if (q_shift < Q_MIN) begin
            level_d = 5'd0;
        end else begin
            // q is within [-8, 8], so the low five bits plus 8 wrap to the right level.
            level_d = q_shift[4:0] + 5'd8;
        end

        if (df_q > 5'd16) begin
            delta = 6'sd0;
        end else begin
            delta = $signed({1'b0, df_q}) - 6'sd8;
        end

        // Two's-complement wrap in SUM_W bits is exact, because the true sum always fits.
        sum_full = {{(SUM_W-OUT_W){out_u_q[OUT_W-1]}}, out_u_q}
                 + {{(SUM_W-6){delta[5]}}, delta} * GAIN_EXT;
        if (sum_full > SUM_MAX) begin
            sum_d = OUT_MAX;
        end else if (sum_full < SUM_MIN) begin
            sum_d = OUT_MIN;
        end else begin
            sum_d = sum_full[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            e_cur_q     <= '0;
            e_prev_q    <= '0;
            first_q     <= 1'b1;
            ec_q        <= '0;
            level_q     <= 5'd8;
            df_q        <= 5'd8;
            out_u_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            df_err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (clr) begin
                        out_u_q  <= '0;
                        e_prev_q <= '0;
                        first_q  <= 1'b1;
                        level_q  <= 5'd8;
                    end else if (bus.in_valid) begin
                        e_cur_q    <= bus.in_err;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_DIFF;
                    end
                end
                S_DIFF: begin
                    ec_q     <= first_q ? '0 : ec_d;
                    first_q  <= 1'b0;
                    e_prev_q <= e_cur_q;
                    state_q  <= S_QUANT;
                end
                S_QUANT: begin
                    level_q <= level_d;
                    state_q <= S_INFER;
                end
                S_INFER: begin
                    // The table output settles during this cycle and is captured at its end.
                    df_q     <= bus.fuzzy_df;
                    df_err_q <= (bus.fuzzy_df > 5'd16);
                    state_q  <= S_ACC;
                end
                S_ACC: begin
                    df_err_q    <= 1'b0;
                    out_u_q     <= sum_d;
                    out_valid_q <= 1'b1;
                    state_q     <= S_OUT;
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    df_err_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.fuzzy_EC  = level_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_u     = out_u_q;
    assign bus.df_err    = df_err_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_fuzzy_step_sched_2.sv
// Testbench for fuzzy_step_sched_2. Two instances (GAIN=1 and GAIN=4096) share the same stimulus.
// Their results are checked against a table of vectors and against an arithmetic reference model.
module tb_fuzzy_step_sched_2;
    localparam int     W      = 16;
    localparam int     OUT_W  = 16;
    localparam int     QSHIFT = 4;
    localparam longint G1     = 1;
    localparam longint G2     = 4096;

    logic               clk;
    logic               rst;
    logic               clr;
    logic               in_valid;
    logic signed [15:0] in_err;
    logic               out_ready;
    int                 df_force;

    int n_checks = 0;
    int n_pass   = 0;

    fuzzy_step_sched_2_if #(.W(W), .OUT_W(OUT_W)) if1 ();
    fuzzy_step_sched_2_if #(.W(W), .OUT_W(OUT_W)) if2 ();

    assign if1.in_valid  = in_valid;
    assign if1.in_err    = in_err;
    assign if1.out_ready = out_ready;
    assign if1.fuzzy_df  = (df_force >= 0) ? df_force[4:0] : if1.fuzzy_EC;
    assign if2.in_valid  = in_valid;
    assign if2.in_err    = in_err;
    assign if2.out_ready = out_ready;
    assign if2.fuzzy_df  = (df_force >= 0) ? df_force[4:0] : if2.fuzzy_EC;

    fuzzy_step_sched_2 #(.W(W), .QSHIFT(QSHIFT), .GAIN(1), .OUT_W(OUT_W)) dut1 (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (if1)
    );

    fuzzy_step_sched_2 #(.W(W), .QSHIFT(QSHIFT), .GAIN(4096), .OUT_W(OUT_W)) dut2 (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    int     m_prev;
    bit     m_first;
    longint m_acc [2];

    function automatic longint sat(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model_reset();
        m_prev   = 0;
        m_first  = 1'b1;
        m_acc[0] = 0;
        m_acc[1] = 0;
    endtask

    task automatic model_step(input int err, input int frc, output int lvl, output bit bad);
        longint ec;
        longint q;
        longint d;
        int     df;
        ec      = m_first ? 0 : longint'(err) - longint'(m_prev);
        m_first = 1'b0;
        m_prev  = err;
        if (ec >= 0) q = ec / (1 << QSHIFT);
        else         q = -((-ec + (1 << QSHIFT) - 1) / (1 << QSHIFT));
        if (q > 8)  q = 8;
        if (q < -8) q = -8;
        lvl = int'(q) + 8;
        df  = (frc >= 0) ? frc : lvl;
        bad = (df > 16);
        d   = bad ? 0 : longint'(df) - 8;
        m_acc[0] = sat(m_acc[0] + d * G1);
        m_acc[1] = sat(m_acc[1] + d * G2);
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!(if1.in_ready && if2.in_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", longint'(n < 20), 1);
    endtask

    // Send one sample with out_ready high and check each stage on the way through.
    task automatic apply(input int err, input int frc, input int e_lvl, input bit e_bad,
                         input longint e_u1, input longint e_u2);
        wait_ready();
        df_force = frc;
        in_err   = 16'(err);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("in_ready_low_diff", if1.in_ready, 0);
        chk("busy_diff", if2.busy, 1);
        @(negedge clk);
        @(negedge clk);
        chk("fuzzy_EC_g1", if1.fuzzy_EC, e_lvl);
        chk("fuzzy_EC_g4096", if2.fuzzy_EC, e_lvl);
        @(negedge clk);
        chk("df_err_acc_g1", if1.df_err, e_bad);
        chk("df_err_acc_g4096", if2.df_err, e_bad);
        chk("out_valid_acc", if1.out_valid, 0);
        @(negedge clk);
        chk("out_valid_out", if1.out_valid, 1);
        chk("out_u_g1", $signed(if1.out_u), e_u1);
        chk("out_u_g4096", $signed(if2.out_u), e_u2);
        chk("df_err_out", if1.df_err | if2.df_err, 0);
        $display("sample err=%0d df_force=%0d level=%0d u_g1=%0d u_g4096=%0d",
                 err, frc, if1.fuzzy_EC, $signed(if1.out_u), $signed(if2.out_u));
        @(negedge clk);
        df_force = -1;
    endtask

    task automatic model_apply(input int err, input int frc);
        int lvl;
        bit bad;
        model_step(err, frc, lvl, bad);
        apply(err, frc, lvl, bad, m_acc[0], m_acc[1]);
    endtask

    // Assert clr together with a valid sample in IDLE. The clear has priority, so the sample is dropped.
    task automatic apply_clr();
        wait_ready();
        clr      = 1'b1;
        in_valid = 1'b1;
        in_err   = 16'sd12345;
        @(negedge clk);
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("clr_in_ready", if1.in_ready & if2.in_ready, 1);
        chk("clr_busy", if1.busy | if2.busy, 0);
        chk("clr_out_u_g1", $signed(if1.out_u), 0);
        chk("clr_out_u_g4096", $signed(if2.out_u), 0);
        chk("clr_fuzzy_EC", if1.fuzzy_EC, 8);
        $display("clear with in_valid held high");
        model_reset();
    endtask

    typedef struct {
        bit     do_clr;
        int     err;
        int     frc;
        int     lvl;
        bit     bad;
        longint u1;
        longint u2;
    } vec_t;

    vec_t tbl [17];

    initial begin
        int     lvl;
        bit     bad;
        longint hold1;
        longint hold2;

        tbl[0]  = '{0,     0, -1,  8, 0,   0,      0};
        tbl[1]  = '{0,    48, -1, 11, 0,   3,  12288};
        tbl[2]  = '{0, -1000, -1,  0, 0,  -5, -20480};
        tbl[3]  = '{1,     0, -1,  8, 0,   0,      0};
        tbl[4]  = '{0,   200, -1, 16, 0,   8,  32767};
        tbl[5]  = '{0,   400, -1, 16, 0,  16,  32767};
        tbl[6]  = '{0, -1000, -1,  0, 0,   8,     -1};
        tbl[7]  = '{0, -1000, 20,  8, 1,   8,     -1};
        tbl[8]  = '{0, -1017, -1,  6, 0,   6,  -8193};
        tbl[9]  = '{0, -1002, -1,  8, 0,   6,  -8193};
        tbl[10] = '{0, -1018, -1,  7, 0,   5, -12289};
        tbl[11] = '{0,  -890, -1, 16, 0,  13,  20479};
        tbl[12] = '{0,  -890, 16,  8, 0,  21,  32767};
        tbl[13] = '{0,  -890, 17,  8, 1,  21,  32767};
        tbl[14] = '{0,  -890,  0,  8, 0,  13,     -1};
        tbl[15] = '{0,  -890,  0,  8, 0,   5, -32768};
        tbl[16] = '{0,  -890,  0,  8, 0,  -3, -32768};

        rst       = 1'b1;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_err    = '0;
        out_ready = 1'b1;
        df_force  = -1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", if1.in_ready & if2.in_ready, 1);
        chk("rst_fuzzy_EC", if1.fuzzy_EC, 8);
        chk("rst_out_valid", if1.out_valid | if2.out_valid, 0);
        chk("rst_out_u", $signed(if1.out_u), 0);
        chk("rst_df_err", if1.df_err, 0);
        chk("rst_busy", if1.busy | if2.busy, 0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            if (tbl[i].do_clr) apply_clr();
            model_step(tbl[i].err, tbl[i].frc, lvl, bad);
            apply(tbl[i].err, tbl[i].frc, tbl[i].lvl, tbl[i].bad, tbl[i].u1, tbl[i].u2);
        end

        // Backpressure: hold OUT for 10 cycles and check that a stray sample and a clr are both ignored.
        wait_ready();
        model_step(123, -1, lvl, bad);
        in_err    = 16'sd123;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("bp_out_valid", if1.out_valid, 1);
        chk("bp_out_u_g1", $signed(if1.out_u), m_acc[0]);
        chk("bp_out_u_g4096", $signed(if2.out_u), m_acc[1]);
        hold1 = $signed(if1.out_u);
        hold2 = $signed(if2.out_u);
        for (int c = 0; c < 10; c++) begin
            in_valid = (c == 3);
            in_err   = 16'sd777;
            clr      = (c == 6);
            @(negedge clk);
            chk("bp_hold_valid", if1.out_valid & if2.out_valid, 1);
            chk("bp_hold_u_g1", $signed(if1.out_u), hold1);
            chk("bp_hold_u_g4096", $signed(if2.out_u), hold2);
            chk("bp_hold_in_ready", if1.in_ready | if2.in_ready, 0);
        end
        in_valid  = 1'b0;
        clr       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", if1.out_valid | if2.out_valid, 0);
        chk("bp_release_ready", if1.in_ready & if2.in_ready, 1);
        chk("bp_release_busy", if1.busy | if2.busy, 0);
        $display("backpressure hold of 10 cycles released");
        model_apply(200, -1);

        // Reset during INFER discards the sample in flight.
        wait_ready();
        in_err   = 16'sd999;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_infer_in_ready", if1.in_ready & if2.in_ready, 1);
        chk("rst_infer_busy", if1.busy | if2.busy, 0);
        chk("rst_infer_out_valid", if1.out_valid | if2.out_valid, 0);
        chk("rst_infer_out_u_g4096", $signed(if2.out_u), 0);
        chk("rst_infer_fuzzy_EC", if1.fuzzy_EC, 8);
        @(negedge clk);
        chk("rst_infer_no_valid", if1.out_valid | if2.out_valid, 0);
        $display("reset applied during INFER");
        model_reset();
        model_apply(-500, -1);

        for (int r = 0; r < 40; r++) begin
            int err;
            int frc;
            if ($urandom_range(0, 9) == 0) apply_clr();
            if ($urandom_range(0, 3) == 0) err = int'($urandom_range(0, 65535)) - 32768;
            else                           err = int'($urandom_range(0, 400)) - 200;
            frc = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 31)) : -1;
            model_apply(err, frc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
